serial_addsub: RTL

Parametrised bit-serial add/subtract unit: processes two WIDTH-bit operands LSB first, one bit per clock, through a single full-subtract/full-add cell with a registered borrow/carry. It sits between a control FSM and a register file. Area-constrained datapaths use it where a WIDTH-bit ripple array is too large. Handshake is start/busy/done. Registered result, carry/borrow-out and signed overflow hold until the next operation completes.

---
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_addsub.sv | 116 +++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Start/busy/done handshake and operand/result bundle for serial_addsub.
// The master side issues operations; the slave side is the arithmetic unit.
interface serial_addsub_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cb;
   logic             ovf;

   modport master (
      output start, mode, a, b,
      input  busy, done, result, cb, ovf
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, result, cb, ovf
   );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-add/full-subtract cell, LSB first, one bit per clock.
// Result, carry/borrow-out and signed overflow are registered and held until the next completion.
module serial_addsub #(
   parameter int unsigned WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   serial_addsub_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] work_q;
   logic             mode_q;
   logic             c_q;
   logic             a_msb_q;
   logic             b_msb_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             cb_q;
   logic             ovf_q;

   logic             ai;
   logic             bi;
   logic             bit_out;
   logic             c_next;
   logic             ovf_next;
   logic [WIDTH-1:0] work_next;

   // Single shared cell: mode picks carry (add) or borrow (subtract) propagation.
   always_comb begin
      ai        = a_sh_q[0];
      bi        = b_sh_q[0];
      bit_out   = ai ^ bi ^ c_q;
      c_next    = mode_q ? ((ai & bi) | (c_q & (ai ^ bi)))
                         : ((~ai & bi) | (~(ai ^ bi) & c_q));
      work_next = {bit_out, work_q[WIDTH-1:1]};
      if (mode_q) begin
         ovf_next = (a_msb_q == b_msb_q) & (bit_out != a_msb_q);
      end else begin
         ovf_next = (a_msb_q != b_msb_q) & (bit_out != a_msb_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         work_q   <= '0;
         mode_q   <= 1'b0;
         c_q      <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cb_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  a_sh_q  <= bus.a;
                  b_sh_q  <= bus.b;
                  mode_q  <= bus.mode;
                  a_msb_q <= bus.a[WIDTH-1];
                  b_msb_q <= bus.b[WIDTH-1];
                  work_q  <= '0;
                  c_q     <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               a_sh_q <= a_sh_q >> 1;
               b_sh_q <= b_sh_q >> 1;
               work_q <= work_next;
               c_q    <= c_next;
               cnt_q  <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  result_q <= work_next;
                  cb_q     <= c_next;
                  ovf_q    <= ovf_next;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= StDone;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.cb     = cb_q;
   assign bus.ovf    = ovf_q;
endmodule
